// File: rtl/binary_fraction_divider.sv
// binary_fraction_divider
// Sequential sign-magnitude fixed-point divider, the inverse of the neuron
// fraction multiplier. Product-format dividend (sign + 22 bits, 10 frac) over
// weight-format divisor (sign + 2 bits, 1 frac) gives an input-format quotient
// (sign + 11 bits, 9 frac). Restoring division, one quotient bit per clock.
// Optional build macro DIV_ROUND_EN: round half up on the magnitude instead of
// truncating toward zero.
module binary_fraction_divider #(
   parameter int O_DATA = 22,
   parameter int I_DATA = 11,
   parameter int W_DATA = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [O_DATA:0] dividend,
   input  logic [W_DATA:0] divisor,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [I_DATA:0] quotient,
   output logic            div_zero,
   output logic            overflow
);
   localparam int CNT_W = $clog2(O_DATA + 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   typedef struct packed {
      logic [I_DATA:0] q;
      logic            dz;
      logic            ov;
   } res_t;

   state_t            state, state_d;
   logic [W_DATA-1:0] rem, rem_d;
   logic [W_DATA-1:0] dmag, dmag_d;
   logic [O_DATA-1:0] sr, sr_d;      // dividend bits shift out, quotient bits shift in
   logic [CNT_W-1:0]  cnt, cnt_d;
   logic              sign, sign_d;
   res_t              res, res_d;

   logic [W_DATA:0]   rem_sh;
   logic              bit_ge;
   logic [W_DATA-1:0] rem_it;
   logic [O_DATA-1:0] q_full;
   logic              ovf_q;
   logic [I_DATA-1:0] mag_q;
   logic              sgn_q;

   // one restoring-division step: bring down the next dividend bit, try subtract
   always_comb begin
      rem_sh = {rem, sr[O_DATA-1]};
      bit_ge = (rem_sh >= {1'b0, dmag});
      rem_it = bit_ge ? W_DATA'(rem_sh - {1'b0, dmag}) : W_DATA'(rem_sh);
      q_full = {sr[O_DATA-2:0], bit_ge};
   end

   // final magnitude/sign from the full quotient of the last step; the remainder
   // after the last step is still at hand for optional rounding
   always_comb begin
      ovf_q = |q_full[O_DATA-1:I_DATA];
      mag_q = ovf_q ? '1 : q_full[I_DATA-1:0];
`ifdef DIV_ROUND_EN
      if (!ovf_q && ({rem_it, 1'b0} >= {1'b0, dmag})) begin
         if (&mag_q) ovf_q = 1'b1;
         else        mag_q = mag_q + I_DATA'(1);
      end
`endif
      sgn_q = sign & (|mag_q);   // never emit negative zero
   end

   // next-state and datapath load decisions
   always_comb begin
      state_d = state;
      rem_d   = rem;
      dmag_d  = dmag;
      sr_d    = sr;
      cnt_d   = cnt;
      sign_d  = sign;
      res_d   = res;
      unique case (state)
         IDLE: begin
            if (in_valid) begin
               sign_d = dividend[O_DATA] ^ divisor[W_DATA];
               dmag_d = divisor[W_DATA-1:0];
               sr_d   = dividend[O_DATA-1:0];
               rem_d  = '0;
               if (divisor[W_DATA-1:0] == '0) begin
                  // divide by zero: saturate positive, skip the iterations
                  res_d.q  = {1'b0, {I_DATA{1'b1}}};
                  res_d.dz = 1'b1;
                  res_d.ov = 1'b0;
                  state_d  = DONE;
               end else begin
                  cnt_d   = CNT_W'(O_DATA);
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            rem_d = rem_it;
            sr_d  = q_full;
            cnt_d = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               res_d.q  = {sgn_q, mag_q};
               res_d.dz = 1'b0;
               res_d.ov = ovf_q;
               state_d  = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // state and datapath registers; reset aborts any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         rem   <= '0;
         dmag  <= '0;
         sr    <= '0;
         cnt   <= '0;
         sign  <= 1'b0;
         res   <= '0;
      end else begin
         state <= state_d;
         rem   <= rem_d;
         dmag  <= dmag_d;
         sr    <= sr_d;
         cnt   <= cnt_d;
         sign  <= sign_d;
         res   <= res_d;
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign quotient  = res.q;
   assign div_zero  = res.dz;
   assign overflow  = res.ov;

endmodule

// File: tb/tb_binary_fraction_divider.sv
// Self-checking bench for binary_fraction_divider: directed cases with literal
// expectations plus randomized requests, all checked every cycle against an
// arithmetic reference model. Honours DIV_ROUND_EN the same way as the design.
module tb_binary_fraction_divider;
   logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
   logic [22:0] dividend;
   logic [2:0]  divisor;
   logic [11:0] quotient;
   logic        div_zero, overflow;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct packed {
      logic [11:0] q;
      logic        dz;
      logic        ov;
   } res_t;

   binary_fraction_divider dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
      .out_ready(out_ready), .quotient(quotient), .div_zero(div_zero),
      .overflow(overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // reference: plain integer division of magnitudes
   function automatic res_t model(input logic [22:0] a, input logic [2:0] b);
      longint unsigned ma, mb, q, r;
      logic s;
      res_t o;
      ma = 64'(a[21:0]);
      mb = 64'(b[1:0]);
      s  = a[22] ^ b[2];
      if (mb == 0) begin
         o.q = 12'h7FF; o.dz = 1'b1; o.ov = 1'b0;
         return o;
      end
      q = ma / mb;
      r = ma % mb;
`ifdef DIV_ROUND_EN
      if (2 * r >= mb) q = q + 1;
`else
      if (r > mb) q = 0;   // cannot happen; keeps r referenced
`endif
      o.dz = 1'b0;
      o.ov = (q > 64'h7FF);
      if (o.ov) q = 64'h7FF;
      if (q == 0) s = 1'b0;
      o.q = {s, q[10:0]};
      return o;
   endfunction

   function automatic res_t got();
      res_t o;
      o.q = quotient; o.dz = div_zero; o.ov = overflow;
      return o;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chkr(input string nm, input res_t act, input res_t exp);
      chk(nm, 32'(act), 32'(exp));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // per-cycle compare against the model's view of the handshake timeline
   int   mode = 0;     // 0 idle, 1 computing, 2 result presented
   int   left = 0;
   res_t held = '0;
   res_t pend = '0;
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mode = 0;
            held = '0;
         end
         chk("mon_in_ready", 32'(in_ready), 32'(mode == 0));
         chk("mon_out_valid", 32'(out_valid), 32'(mode == 2));
         chkr("mon_result", got(), held);
         if (rst_n) begin
            case (mode)
               0: if (in_valid) begin
                  pend = model(dividend, divisor);
                  if (pend.dz) begin mode = 2; held = pend; end
                  else begin mode = 1; left = 22; end
               end
               1: begin
                  left--;
                  if (left == 0) begin mode = 2; held = pend; end
               end
               default: if (out_ready) mode = 0;
            endcase
         end
      end
   end

   task automatic xact(input logic [22:0] a, input logic [2:0] b, input int hold,
                       input bit use_lit, input res_t lit);
      res_t m, e;
      int n, lat;
      m = model(a, b);
      e = use_lit ? lit : m;
      dividend = a; divisor = b; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 200) begin tick(); n++; end
      chk("accept_timeout", 32'(n < 200), 32'd1);
      tick();
      in_valid = 1'b0;
      dividend = 23'($urandom);   // must be ignored while busy
      divisor  = 3'($urandom);
      lat = 1;
      while (!out_valid && lat < 100) begin tick(); lat++; end
      chk("latency", 32'(lat), m.dz ? 32'd1 : 32'd23);
      chkr("result", got(), e);
      repeat (hold) begin
         tick();
         chk("hold_valid", 32'(out_valid), 32'd1);
         chkr("hold_result", got(), e);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("valid_drop", 32'(out_valid), 32'd0);
      chk("ready_back", 32'(in_ready), 32'd1);
      chkr("result_kept", got(), e);
   endtask

   task automatic b2b(input logic [22:0] a1, input logic [2:0] b1,
                      input logic [22:0] a2, input logic [2:0] b2);
      res_t m1, m2;
      int n, lat;
      m1 = model(a1, b1);
      m2 = model(a2, b2);
      dividend = a1; divisor = b1; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 200) begin tick(); n++; end
      tick();
      dividend = a2; divisor = b2;   // keep requesting while busy
      n = 0;
      while (!out_valid && n < 100) begin
         chk("b2b_busy_ready", 32'(in_ready), 32'd0);
         tick(); n++;
      end
      chkr("b2b_first", got(), m1);
      repeat (5) begin
         tick();
         chk("b2b_hold_ready", 32'(in_ready), 32'd0);
         chkr("b2b_hold_first", got(), m1);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("b2b_idle", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      chk("b2b_second_taken", 32'(in_ready), 32'd0);
      lat = 1;
      while (!out_valid && lat < 100) begin tick(); lat++; end
      chk("b2b_latency", 32'(lat), m2.dz ? 32'd1 : 32'd23);
      chkr("b2b_second", got(), m2);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      res_t r5;
      logic [22:0] a;
      logic [2:0]  b;
      int n;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      dividend = '0; divisor = '0;
`ifdef DIV_ROUND_EN
      r5 = {12'h002, 1'b0, 1'b0};
`else
      r5 = {12'h001, 1'b0, 1'b0};
`endif
      // hand-computed pins on the reference model
      chkr("pin_plus1_by_minus1", model(23'h000400, 3'b110), {12'hA00, 1'b0, 1'b0});
      chkr("pin_div_zero", model(23'h400400, 3'b000), {12'h7FF, 1'b1, 1'b0});
      chkr("pin_sat_pos", model(23'h3FFFFF, 3'b001), {12'h7FF, 1'b0, 1'b1});
      chkr("pin_sat_neg", model(23'h7FFFFF, 3'b001), {12'hFFF, 1'b0, 1'b1});
      chkr("pin_5_by_3", model(23'h000005, 3'b011), r5);
      chkr("pin_neg_zero", model(23'h400000, 3'b001), {12'h000, 1'b0, 1'b0});

      repeat (3) tick();
      chkr("reset_result", got(), '0);
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      rst_n = 1'b1;
      tick();

      xact(23'h000400, 3'b110, 4, 1, {12'hA00, 1'b0, 1'b0});
      xact(23'h400400, 3'b000, 1, 1, {12'h7FF, 1'b1, 1'b0});
      xact(23'h3FFFFF, 3'b001, 0, 1, {12'h7FF, 1'b0, 1'b1});
      xact(23'h7FFFFF, 3'b001, 0, 1, {12'hFFF, 1'b0, 1'b1});
      xact(23'h000005, 3'b011, 0, 1, r5);
      xact(23'h400000, 3'b001, 0, 1, {12'h000, 1'b0, 1'b0});

      b2b(23'h000C00, 3'b010, 23'h401234, 3'b011);

      // reset in the middle of an operation
      dividend = 23'h00ABCD; divisor = 3'b001; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 200) begin tick(); n++; end
      tick();
      in_valid = 1'b0;
      repeat (9) tick();
      rst_n = 1'b0;
      #1;
      chkr("async_reset_result", got(), '0);
      chk("async_reset_in_ready", 32'(in_ready), 32'd1);
      chk("async_reset_out_valid", 32'(out_valid), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      xact(23'h00ABCD, 3'b001, 1, 1, {12'h7FF, 1'b0, 1'b1});

      for (int i = 0; i < 40; i++) begin
         a = 23'($urandom);
         case ($urandom_range(0, 3))
            0: a[21:11] = '0;
            1: a[21:12] = '0;
            default: ;
         endcase
         b = 3'($urandom);
         xact(a, b, $urandom_range(0, 3), 0, '0);
         repeat ($urandom_range(0, 2)) tick();
      end

      tick();
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
